// File: rtl/command_frame_assembler.sv
// Command frame assembler: packs NUM_BYTES handshaked bytes into one
// frame word, holds it for the decoder, and drops stalled partial frames.
`timescale 1ns/1ps
module command_frame_assembler #(
  parameter int NUM_BYTES      = 4,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int NUM_BITS       = NUM_BYTES*8,
  parameter int CNT_W          = $clog2(NUM_BYTES+1)
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Clear,
  input  logic [7:0]          ByteIn,
  input  logic                ByteValid,
  output logic                ByteReady,
  output logic [NUM_BITS-1:0] RegValues,
  output logic                CmdValid,
  input  logic                CmdAck,
  output logic [CNT_W-1:0]    ByteCount,
  output logic                TimeoutPulse
);

  localparam int TMO_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES+1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES-1 : 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES-1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] reg_q, reg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                pulse_q, pulse_d;
  logic                accept;
  logic [NUM_BITS-1:0] shifted;

  assign ByteReady    = (state_q != HOLD) && !Clear;
  assign accept       = ByteValid && ByteReady;
  assign CmdValid     = (state_q == HOLD);
  assign RegValues    = reg_q;
  assign ByteCount    = cnt_q;
  assign TimeoutPulse = pulse_q;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {reg_q[NUM_BITS-9:0], ByteIn};
    end else begin : g_lsb
      assign shifted = {ByteIn, reg_q[NUM_BITS-1:8]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    pulse_d = 1'b0;
    if (Clear) begin
      state_d = IDLE;
      reg_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            reg_d   = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = FILL;
          end
        end
        FILL: begin
          if (accept) begin
            reg_d = shifted;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = HOLD;
          end else if (TMO_EN && tmo_q == TMO_LAST) begin
            // stalled partial frame: discard and flag it
            state_d = IDLE;
            reg_d   = '0;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else if (TMO_EN) begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        HOLD: begin
          if (CmdAck) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          reg_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      reg_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      pulse_q <= pulse_d;
    end
  end

endmodule
